// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIV_DW    = 16;
    localparam int DIV_VW    = 8;
    localparam int DIV_CNT_W = $clog2(DIV_DW + 1);

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int VW = DIV_VW
) (
    input  logic [VW:0]   pr_in,
    input  logic          din,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   pr_out,
    output logic          q_bit
);

    logic [VW:0] shifted;
    logic        fits;

    // A set pr_in MSB means the true shifted value exceeds any VW-bit divisor.
    assign shifted = {pr_in[VW-1:0], din};
    assign fits    = pr_in[VW] | (shifted >= {1'b0, divisor});
    assign pr_out  = fits ? (shifted - {1'b0, divisor}) : shifted;
    assign q_bit   = fits;

endmodule

// File: rtl/seq_divider.sv
// Iterative 16/8 restoring divider with start/done handshake.
// Define APPROX_DIV_EN to skip the low TRUNC_BITS quotient bits (remainder forced to zero).
module seq_divider
    import div_pkg::*;
#(
    parameter int DW         = DIV_DW,
    parameter int VW         = DIV_VW,
    parameter int TRUNC_BITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

`ifdef APPROX_DIV_EN
    localparam int ITER = DW - TRUNC_BITS;
`else
    localparam int ITER = DW;
`endif
    localparam int CW = $clog2(DW + 1);

    state_t          state, state_nxt;
    logic            accept;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dvd_sh;
    logic [DW-2:0]   q_sh;
    logic [VW:0]     pr;
    logic [VW-1:0]   dvs;
    logic            zero;
    logic [VW:0]     pr_nxt;
    logic            q_bit;
    logic [DW-1:0]   q_final;
    logic [VW-1:0]   r_final;

    div_step #(.VW(VW)) u_step (
        .pr_in   (pr),
        .din     (dvd_sh[DW-1]),
        .divisor (dvs),
        .pr_out  (pr_nxt),
        .q_bit   (q_bit)
    );

`ifdef APPROX_DIV_EN
    assign q_final = {q_sh, q_bit} << TRUNC_BITS;
    assign r_final = '0;
`else
    assign q_final = {q_sh, q_bit};
    assign r_final = pr_nxt[VW-1:0];
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (divisor == '0 || ITER <= 1)
                        state_nxt = DONE;
                    else
                        state_nxt = RUN;
                end
            end
            RUN:     if (cnt == CW'(2)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == DONE);
            if (accept)
                dbz <= 1'b0;
            // DONE performs the last step and registers the result in one edge
            if (state == DONE) begin
                dbz       <= zero;
                quotient  <= zero ? '1 : q_final;
                remainder <= zero ? dvd_sh[VW-1:0] : r_final;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_sh <= dividend;
            dvs    <= divisor;
            zero   <= (divisor == '0);
            pr     <= '0;
            q_sh   <= '0;
            cnt    <= CW'(ITER);
        end else if (state == RUN) begin
            dvd_sh <= dvd_sh << 1;
            pr     <= pr_nxt;
            q_sh   <= {q_sh[DW-3:0], q_bit};
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operands, monitor pops expected results on done.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

`ifdef APPROX_DIV_EN
    localparam bit APPROX = 1'b1;
`else
    localparam bit APPROX = 1'b0;
`endif
    localparam int LAT = APPROX ? 13 : 16;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done_seen), 32'(done_exp));
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_quotient"}, 32'(quotient), 32'(e.q));
                chk({e.tag, "_remainder"}, 32'(remainder), 32'(e.r));
                chk({e.tag, "_dbz"}, 32'(dbz), 32'(e.z));
                chk({e.tag, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                chk({e.tag, "_busy_low"}, 32'(busy), 32'd0);
            end
        end
    end

    task automatic push_exp(input string tag, input logic [15:0] qx, input logic [7:0] rx,
                            input logic [15:0] qa, input logic [7:0] ra, input logic z, input int lat);
        exp_t e;
        e.q   = APPROX ? qa : qx;
        e.r   = APPROX ? ra : rx;
        e.z   = z;
        e.lat = lat;
        e.acc = cyc;
        e.tag = tag;
        sb.push_back(e);
        done_exp++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic issue(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] qx, input logic [7:0] rx,
                         input logic [15:0] qa, input logic [7:0] ra, input logic z, input int lat);
        wait_idle();
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk); #1;
        push_exp(tag, qx, rx, qa, ra, z, lat);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(dbz), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        issue("t1_1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 16'd136, 8'd0, 1'b0, LAT);
        drain("t1");
        issue("t2_ffff_1", 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 16'hFFF8, 8'd0, 1'b0, LAT);
        drain("t2a");
        issue("t2_5_9", 16'd5, 8'd9, 16'd0, 8'd5, 16'd0, 8'd0, 1'b0, LAT);
        drain("t2b");
        issue("t3_dbz", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 16'hFFFF, 8'h34, 1'b1, 1);
        drain("t3a");
        issue("t3_10_3", 16'd10, 8'd3, 16'd3, 8'd1, 16'd0, 8'd0, 1'b0, LAT);
        drain("t3b");
        issue("ffff_255", 16'hFFFF, 8'd255, 16'd257, 8'd0, 16'd256, 8'd0, 1'b0, LAT);
        drain("x1");
        issue("12345_100", 16'd12345, 8'd100, 16'd123, 8'd45, 16'd120, 8'd0, 1'b0, LAT);
        drain("x2");

        // start held high with different operands while the first division runs
        issue("t4_held", 16'd1000, 8'd7, 16'd142, 8'd6, 16'd136, 8'd0, 1'b0, LAT);
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
        drain("t4");
        repeat (20) @(posedge clk);
        #1;

        // reset in the middle of an operation
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_busy_mid", 32'(busy), 32'd1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_quotient", 32'(quotient), 32'd0);
        chk("t5_remainder", 32'(remainder), 32'd0);
        chk("t5_dbz", 32'(dbz), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        issue("t5_after", 16'd1000, 8'd7, 16'd142, 8'd6, 16'd136, 8'd0, 1'b0, LAT);
        drain("t5");
        repeat (5) @(posedge clk);
        #1;

        chk("done_pulse_count", 32'(done_seen), 32'(done_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
